// File: rtl/quadrature_decoder_counter.sv
// Quadrature encoder front end: per-input glitch filter, X1/X2/X4 step decode,
// illegal-transition tracking and a wrapping signed position counter with index zeroing.
module quadrature_decoder_counter #(
   parameter int COUNT_WIDTH = 32,
   parameter int FILTER_LEN  = 3,
   parameter int ERR_WIDTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          quadA_in,
   input  logic                          quadB_in,
   input  logic                          quadI_in,
   input  logic [1:0]                    mode,
   input  logic                          enable,
   input  logic                          clear,
   input  logic                          index_clear_en,
   output logic                          count_pulse,
   output logic                          direction,
   output logic signed [COUNT_WIDTH-1:0] position,
   output logic                          index_pulse,
   output logic                          index_seen,
   output logic                          error,
   output logic [ERR_WIDTH-1:0]          err_count
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int ICW = $clog2(FILTER_LEN + 2);
   localparam logic [FCW-1:0]         FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [FCW-1:0]         FILT_ONE  = FCW'(1'b1);
   localparam logic [FCW-1:0]         FILT_ZERO = FCW'(1'b0);
   localparam logic [ICW-1:0]         INIT_LAST = ICW'(FILTER_LEN);
   localparam logic [ICW-1:0]         INIT_ONE  = ICW'(1'b1);
   localparam logic [COUNT_WIDTH-1:0] POS_ONE   = COUNT_WIDTH'(1'b1);
   localparam logic [COUNT_WIDTH-1:0] POS_ZERO  = COUNT_WIDTH'(1'b0);
   localparam logic [ERR_WIDTH-1:0]   ERR_ONE   = ERR_WIDTH'(1'b1);
   localparam logic [ERR_WIDTH-1:0]   ERR_ZERO  = ERR_WIDTH'(1'b0);
   localparam logic [ERR_WIDTH-1:0]   ERR_MAX   = {ERR_WIDTH{1'b1}};

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                 state_r, state_s;
   logic [ICW-1:0]         init_cnt_r;
   logic                   run_s;
   logic [2:0]             raw_s;
   logic [2:0]             filt_r;
   logic [2:0]             prev_r;
   logic [FCW-1:0]         fcnt_r [3];
   logic                   active_s, step_s, fwd_s, illegal_s, count_s, idx_rise_s;
   logic [3:0]             trans_s;
   logic                   count_pulse_r, direction_r, index_pulse_r, index_seen_r, error_r;
   logic [COUNT_WIDTH-1:0] position_r;
   logic [ERR_WIDTH-1:0]   err_count_r;

   assign raw_s   = {quadA_in, quadB_in, quadI_in};
   assign trans_s = {prev_r[2:1], filt_r[2:1]};

   // State register and INIT dwell counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_INIT;
         init_cnt_r <= {ICW{1'b0}};
      end else begin
         state_r <= state_s;
         if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + INIT_ONE;
         end else begin
            init_cnt_r <= init_cnt_r;
         end
      end
   end

   // Next-state logic: INIT lasts FILTER_LEN+1 clocks so filters settle on the resting inputs
   always_comb begin
      state_s = state_r;
      run_s   = 1'b0;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r == INIT_LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            state_s = ST_RUN;
            run_s   = 1'b1;
         end
         default: begin
            state_s = ST_INIT;
         end
      endcase
   end

   // Glitch filters for A, B, I; INIT bypasses them so the resting level is taken as-is
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_r <= 3'b000;
         prev_r <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            fcnt_r[k] <= FILT_ZERO;
         end
      end else begin
         prev_r <= run_s ? filt_r : raw_s;
         for (int k = 0; k < 3; k++) begin
            if (!run_s) begin
               filt_r[k] <= raw_s[k];
               fcnt_r[k] <= FILT_ZERO;
            end else if (raw_s[k] == filt_r[k]) begin
               fcnt_r[k] <= FILT_ZERO;
            end else if (fcnt_r[k] == FILT_LAST) begin
               filt_r[k] <= raw_s[k];
               fcnt_r[k] <= FILT_ZERO;
            end else begin
               fcnt_r[k] <= fcnt_r[k] + FILT_ONE;
            end
         end
      end
   end

   // Transition decode and mode qualification
   always_comb begin
      active_s   = run_s & enable;
      step_s     = 1'b0;
      fwd_s      = 1'b0;
      illegal_s  = 1'b0;
      count_s    = 1'b0;
      case (trans_s)
         4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            step_s = 1'b1;
            fwd_s  = 1'b1;
         end
         4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            step_s = 1'b1;
         end
         4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            illegal_s = 1'b1;
         end
         default: begin
            step_s = 1'b0;
         end
      endcase
      // X1 counts only the 00<->10 pair so reversals cannot drift
      case (mode)
         2'b00:   count_s = step_s & ((trans_s == 4'b0010) | (trans_s == 4'b1000));
         2'b01:   count_s = step_s & (trans_s[3] ^ trans_s[1]);
         default: count_s = step_s;
      endcase
      count_s    = count_s & active_s;
      step_s     = step_s & active_s;
      illegal_s  = illegal_s & active_s;
      idx_rise_s = active_s & filt_r[0] & ~prev_r[0];
   end

   // Registered outputs; position priority is clear, then index zero, then step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_pulse_r <= 1'b0;
         direction_r   <= 1'b0;
         position_r    <= POS_ZERO;
         index_pulse_r <= 1'b0;
         index_seen_r  <= 1'b0;
         error_r       <= 1'b0;
         err_count_r   <= ERR_ZERO;
      end else begin
         count_pulse_r <= count_s & ~clear;
         index_pulse_r <= idx_rise_s;
         if (step_s && !clear) begin
            direction_r <= fwd_s;
         end
         if (clear) begin
            position_r <= POS_ZERO;
         end else if (idx_rise_s && index_clear_en) begin
            position_r <= POS_ZERO;
         end else if (count_s) begin
            position_r <= fwd_s ? (position_r + POS_ONE) : (position_r - POS_ONE);
         end
         if (clear) begin
            index_seen_r <= 1'b0;
            error_r      <= 1'b0;
            err_count_r  <= ERR_ZERO;
         end else begin
            if (idx_rise_s) begin
               index_seen_r <= 1'b1;
            end
            if (illegal_s) begin
               error_r <= 1'b1;
               if (err_count_r != ERR_MAX) begin
                  err_count_r <= err_count_r + ERR_ONE;
               end
            end
         end
      end
   end

   assign count_pulse = count_pulse_r;
   assign direction   = direction_r;
   assign position    = position_r;
   assign index_pulse = index_pulse_r;
   assign index_seen  = index_seen_r;
   assign error       = error_r;
   assign err_count   = err_count_r;

endmodule

// File: doc/quadrature_decoder_counter.md
Name: quadrature_decoder_counter

Overview:
- Parametrised successor to the X4 edge decoder.
- Filters synchronised A/B/I encoder inputs with a glitch filter, decodes in run-time selectable X1/X2/X4 mode, and detects illegal (double-change) transitions.
- Maintains a signed wrapping position counter with optional index-triggered zeroing.
- Sits between the input synchronisers and the motor control/readback register file, one instance per encoder channel.

Parameters:
- COUNT_WIDTH, 32, width of the signed position counter (min 8).
- FILTER_LEN, 3, consecutive clocks an input must hold a new value before it is accepted (min 1; 1 = no filtering beyond one register).
- ERR_WIDTH, 8, width of the saturating illegal-transition counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- quadA_in  in  1  synchronised encoder A
- quadB_in  in  1  synchronised encoder B
- quadI_in  in  1  synchronised encoder index
- mode  in  2  00=X1, 01=X2, 10=X4, 11=X4 (reserved)
- enable  in  1  1 = counting active
- clear  in  1  synchronous clear of position, index_seen, error, err_count
- index_clear_en  in  1  1 = index rising edge zeroes position
- count_pulse  out  1  one-cycle pulse per counted step
- direction  out  1  1 = forward (A leads B), 0 = reverse
- position  out  COUNT_WIDTH  signed two's-complement position
- index_pulse  out  1  one-cycle pulse on filtered index rising edge
- index_seen  out  1  sticky, set by index_pulse
- error  out  1  sticky, set on illegal transition
- err_count  out  ERR_WIDTH  saturating count of illegal transitions

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: all outputs 0; filtered A/B/I = 0; filter counters = 0; FSM = INIT.
- Filter (per input):
  - Counter increments while raw != filtered, and resets to 0 when raw == filtered.
  - When the counter reaches FILTER_LEN-1 with raw still different, filtered <= raw.
  - A pulse shorter than FILTER_LEN clocks never propagates.
- FSM states:
  - INIT: filtered A/B/I and prev A/B load directly from raw each clock; no decode, pulses or errors. Leaves to RUN after FILTER_LEN+1 clocks. This prevents a false step or error when the encoder rests at AB=11 after reset.
  - RUN: decode {prevA,prevB} -> {A,B} each clock, then prev <= filtered.
- Decode (RUN):
  - Forward sequence AB: 00->10->11->01->00; reverse is the opposite order.
  - No change: nothing happens.
  - Single-bit change: valid step. direction updates on every valid step (if enable), regardless of mode.
  - Both bits change: illegal. error <= 1, err_count += 1 saturating at all-ones, no count, direction unchanged.
- Mode counting rules:
  - X4: every valid step counts.
  - X2: only steps where A changes (00<->10, 11<->01).
  - X1: only 00<->10 transitions, +1 on 00->10, -1 on 10->00. This is symmetric, so there is no drift on direction reversal.
- Counted step: position +1 forward / -1 reverse, wrapping modulo 2^COUNT_WIDTH (0x7FFFFFFF+1 -> 0x80000000; 0-1 -> all-ones). count_pulse = 1 for exactly that cycle.
- Latency: raw edge first sampled at clock n -> filtered changes at n+FILTER_LEN-1 -> position/count_pulse/direction registered at n+FILTER_LEN.
- Index: rising edge of filtered I in RUN with enable=1 -> index_pulse for 1 cycle and index_seen <= 1. If index_clear_en=1, position <= 0 that cycle, overriding any simultaneous step; count_pulse is still asserted if a step occurred.
- Priority on position: clear > index zero > step.
- clear: zeroes position, index_seen, error and err_count; does not affect direction, filters or FSM. A simultaneous step or error in the same cycle is discarded.
- enable=0: filters, FSM and prev tracking continue; position, direction, pulses, error and err_count hold (pulses 0). Re-enabling never produces a step from the period while disabled.
- mode change takes effect on the next decoded transition; position is not altered.
- Reset asserted mid-operation: immediate return to reset values and INIT.

Test Plan:
- FILTER_LEN=3, X4, enable=1. Drive one full forward cycle 00->10->11->01->00, each state held 10 clk -> 4 count_pulses, position=4, direction=1; each pulse 3 clk after the raw edge.
- Same cycle reversed, in X2 then X1, from position=0 -> position=-2 (all-ones-1) after X2, then -3 after X1; direction=0.
- 2-clk glitch on A (FILTER_LEN=3) -> no count_pulse, position unchanged. Then A and B toggled in the same clock from 00 to 11 -> error=1, err_count=1, position unchanged. 300 such events with ERR_WIDTH=8 -> err_count=255.
- Preload near wrap via forward steps (COUNT_WIDTH=8): position 127 + one forward step -> -128; 0 - 1 -> 255 raw.
- index_clear_en=1, position=57, index rising coincident with forward step -> position=0, index_pulse=1, index_seen=1, count_pulse=1. Next cycle, clear=1 -> index_seen=0, error=0.
- Release reset with A=B=1 held -> no count_pulse and no error through INIT. Assert reset mid-count -> all outputs 0 immediately.
